// File: rtl/cc_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cc_xfer_sequencer
//  Purpose  : Command-driven sequencer for the code converter's four-register
//             shared-bus datapath. Queues MOVE / CONVERT commands in a small
//             FIFO and expands each into a contention-free series of one-hot
//             register and converter load/drive enables.
//  Ports    : clk, rst (async, active-high), abort (sync flush)
//             cmd_valid/cmd_ready/cmd_op/cmd_src/cmd_dst : command push side
//             r_in, r_out, cv_in, cv_out                 : datapath enables
//             busy, done, level                          : status
//  Revision : 1.0 - initial release
// ============================================================================
module cc_xfer_sequencer #(
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          abort,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_op,
   input  logic [1:0]    cmd_src,
   input  logic [1:0]    cmd_dst,
   output logic [3:0]    r_in,
   output logic [3:0]    r_out,
   output logic          cv_in,
   output logic          cv_out,
   output logic          busy,
   output logic          done,
   output logic [LW-1:0] level
);

   localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_MOVE     = 3'd1,
      ST_CV_LOAD  = 3'd2,
      ST_CV_STORE = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   state_t          state_q,   state_d;
   logic [4:0]      mem_q [DEPTH];
   logic [4:0]      mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q,  wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q,  rd_ptr_d;
   logic [LW-1:0]   count_q,   count_d;
   logic            cur_op_q,  cur_op_d;
   logic [1:0]      cur_src_q, cur_src_d;
   logic [1:0]      cur_dst_q, cur_dst_d;

   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   logic [4:0]      head;

   assign fifo_full  = (count_q == FULL_LVL);
   assign fifo_empty = (count_q == '0);
   assign cmd_ready  = !fifo_full && !abort;
   assign push       = cmd_valid && cmd_ready;
   // Head is only consumed from IDLE; abort suppresses the pop entirely.
   assign pop        = (state_q == ST_IDLE) && !fifo_empty && !abort;
   assign head       = mem_q[rd_ptr_q];

   // ------------------------------------------------------------------------
   // Next-state: FIFO bookkeeping, current-command capture, FSM
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      cur_op_d  = cur_op_q;
      cur_src_d = cur_src_q;
      cur_dst_d = cur_dst_q;

      if (abort) begin
         // Flush: drop queue contents and any in-flight command. Moving the
         // read pointer onto the write pointer empties the ring in place.
         state_d  = ST_IDLE;
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = {cmd_op, cmd_src, cmd_dst};
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            cur_op_d  = head[4];
            cur_src_d = head[3:2];
            cur_dst_d = head[1:0];
         end
         case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
         endcase

         case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  state_d = head[4] ? ST_CV_LOAD : ST_MOVE;
               end
            end
            ST_MOVE:     state_d = ST_DONE;
            ST_CV_LOAD:  state_d = ST_CV_STORE;
            ST_CV_STORE: state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         cur_op_q  <= 1'b0;
         cur_src_q <= 2'd0;
         cur_dst_q <= 2'd0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         cur_op_q  <= cur_op_d;
         cur_src_q <= cur_src_d;
         cur_dst_q <= cur_dst_d;
         mem_q     <= mem_d;
      end
   end

   // ------------------------------------------------------------------------
   // Moore output decode: only state and the captured command are used, so
   // an asynchronous reset clears every enable without waiting for a clock.
   // ------------------------------------------------------------------------
   logic [3:0] src_hot;
   logic [3:0] dst_hot;

   assign src_hot = 4'b0001 << cur_src_q;
   assign dst_hot = 4'b0001 << cur_dst_q;

   always_comb begin
      r_in   = 4'b0000;
      r_out  = 4'b0000;
      cv_in  = 1'b0;
      cv_out = 1'b0;
      done   = 1'b0;
      case (state_q)
         ST_MOVE: begin
            // A self-move would drive and load the same register in one
            // cycle; it is treated as a no-op instead.
            if (cur_src_q != cur_dst_q) begin
               r_out = src_hot;
               r_in  = dst_hot;
            end
         end
         ST_CV_LOAD: begin
            r_out = src_hot;
            cv_in = 1'b1;
         end
         ST_CV_STORE: begin
            // Converter drives here, so src==dst is a legal in-place update.
            cv_out = 1'b1;
            r_in   = dst_hot;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            r_in = 4'b0000;
         end
      endcase
   end

   assign busy  = (state_q != ST_IDLE) || !fifo_empty;
   assign level = count_q;

endmodule
`default_nettype wire

// File: tb/tb_cc_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cc_xfer_sequencer
//  Purpose  : Self-checking bench for cc_xfer_sequencer. Directed scenarios
//             compare against fixed expected enable patterns; a randomized
//             phase compares against a queue-based reference model that
//             expands each popped command into its list of per-cycle outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cc_xfer_sequencer;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          abort = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_op = 1'b0;
   logic [1:0]    cmd_src = 2'd0;
   logic [1:0]    cmd_dst = 2'd0;
   logic [3:0]    r_in;
   logic [3:0]    r_out;
   logic          cv_in;
   logic          cv_out;
   logic          busy;
   logic          done;
   logic [LW-1:0] level;

   int total = 0;
   int bad   = 0;

   cc_xfer_sequencer #(.DEPTH(DEPTH), .LW(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .abort     (abort),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_src   (cmd_src),
      .cmd_dst   (cmd_dst),
      .r_in      (r_in),
      .r_out     (r_out),
      .cv_in     (cv_in),
      .cv_out    (cv_out),
      .busy      (busy),
      .done      (done),
      .level     (level)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Bus-exclusivity invariants, every cycle of every test.
   always @(negedge clk) begin
      total++;
      inv_bus: assert (($countones(r_out) + int'(cv_out) <= 1) &&
                       ($countones(r_in) + int'(cv_in) <= 1) &&
                       ((r_out & r_in) == 4'b0000))
      else begin
         bad++;
         $display("FAIL bus_invariant r_out=%b r_in=%b cv_out=%b cv_in=%b",
                  r_out, r_in, cv_out, cv_in);
      end
   end

   // ------------------------------------------------------------------------
   // Reference model: a command queue and a schedule of per-cycle output
   // vectors {done, cv_out, cv_in, r_out[3:0], r_in[3:0]}. An empty schedule
   // means the sequencer is idle and may take the next queued command.
   // ------------------------------------------------------------------------
   logic [4:0]  mq[$];
   logic [10:0] sq[$];

   function automatic logic [10:0] vec(input logic d, input logic co,
                                       input logic ci, input logic [3:0] ro,
                                       input logic [3:0] ri);
      return {d, co, ci, ro, ri};
   endfunction

   function automatic void expand(input logic [4:0] c);
      logic [3:0] s;
      logic [3:0] d;
      s = 4'b0001 << c[3:2];
      d = 4'b0001 << c[1:0];
      if (!c[4]) begin
         if (c[3:2] == c[1:0]) sq.push_back(11'd0);
         else                  sq.push_back(vec(1'b0, 1'b0, 1'b0, s, d));
      end else begin
         sq.push_back(vec(1'b0, 1'b0, 1'b1, s, 4'b0000));
         sq.push_back(vec(1'b0, 1'b1, 1'b0, 4'b0000, d));
      end
      sq.push_back(vec(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
   endfunction

   function automatic void model_edge();
      logic was_full;
      if (abort) begin
         mq.delete();
         sq.delete();
         return;
      end
      was_full = (mq.size() >= DEPTH);
      if (sq.size() > 0) begin
         void'(sq.pop_front());
      end else if (mq.size() > 0) begin
         expand(mq.pop_front());
      end
      if (cmd_valid && !was_full) mq.push_back({cmd_op, cmd_src, cmd_dst});
   endfunction

   function automatic logic [10:0] exp_vec();
      return (sq.size() > 0) ? sq[0] : 11'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         mq.delete();
         sq.delete();
      end else begin
         model_edge();
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic op, input logic [1:0] s,
                        input logic [1:0] d);
      cmd_valid = v;
      cmd_op    = op;
      cmd_src   = s;
      cmd_dst   = d;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      total++;
      if ({done, cv_out, cv_in, r_out, r_in} !== 11'd0) begin
         bad++;
         $display("FAIL reset_enables got=%b want=0", {done, cv_out, cv_in, r_out, r_in});
      end
      total++;
      if (busy !== 1'b0 || level !== '0) begin
         bad++;
         $display("FAIL reset_status busy=%b level=%0d want busy=0 level=0", busy, level);
      end
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready got=%b want=1", cmd_ready);
      end
      abort = 1'b1;
      #1;
      total++;
      if (cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL ready_abort got=%b want=0", cmd_ready);
      end
      abort = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_move();
      drive(1'b1, 1'b0, 2'd0, 2'd2);
      tick();
      drive(1'b0, 1'b0, 2'd0, 2'd0);
      total++;
      if (level !== LW'(1) || busy !== 1'b1 || r_out !== 4'b0000) begin
         bad++;
         $display("FAIL move_queued level=%0d busy=%b r_out=%b want 1 1 0000", level, busy, r_out);
      end
      tick();
      total++;
      if (r_out !== 4'b0001 || r_in !== 4'b0100 || done !== 1'b0) begin
         bad++;
         $display("FAIL move_enables r_out=%b r_in=%b done=%b want 0001 0100 0", r_out, r_in, done);
      end
      tick();
      total++;
      if (r_out !== 4'b0000 || r_in !== 4'b0000 || done !== 1'b1) begin
         bad++;
         $display("FAIL move_done r_out=%b r_in=%b done=%b want 0000 0000 1", r_out, r_in, done);
      end
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL move_idle done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_convert_inplace();
      int ndone;
      drive(1'b1, 1'b1, 2'd3, 2'd3);
      tick();
      drive(1'b0, 1'b0, 2'd0, 2'd0);
      tick();
      total++;
      if ({cv_out, cv_in, r_out, r_in} !== {1'b0, 1'b1, 4'b1000, 4'b0000}) begin
         bad++;
         $display("FAIL cv_load got=%b want=0110000000", {cv_out, cv_in, r_out, r_in});
      end
      tick();
      total++;
      if ({cv_out, cv_in, r_out, r_in} !== {1'b1, 1'b0, 4'b0000, 4'b1000}) begin
         bad++;
         $display("FAIL cv_store got=%b want=1000001000", {cv_out, cv_in, r_out, r_in});
      end
      ndone = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done === 1'b1) ndone++;
      end
      total++;
      if (ndone != 1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL cv_done_count got=%0d busy=%b want 1 0", ndone, busy);
      end
   endtask

   task automatic test_fill();
      logic [3:0] moves[$];
      int         dones[$];
      logic [3:0] want_moves[4];
      want_moves[0] = 4'b0001;
      want_moves[1] = 4'b0010;
      want_moves[2] = 4'b0100;
      want_moves[3] = 4'b1000;
      drive(1'b1, 1'b1, 2'd0, 2'd1); tick();   // CONVERT occupies the FSM
      drive(1'b1, 1'b0, 2'd0, 2'd1); tick();
      drive(1'b1, 1'b0, 2'd1, 2'd2); tick();
      drive(1'b1, 1'b0, 2'd2, 2'd3); tick();
      drive(1'b1, 1'b0, 2'd3, 2'd0); tick();
      total++;
      if (level !== LW'(4) || cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL fill_full level=%0d ready=%b want 4 0", level, cmd_ready);
      end
      drive(1'b1, 1'b0, 2'd2, 2'd1); tick();   // offered while full
      drive(1'b0, 1'b0, 2'd0, 2'd0);
      total++;
      if (level !== LW'(3)) begin
         bad++;
         $display("FAIL fill_fifth_ignored level=%0d want 3", level);
      end
      for (int i = 0; i < 20; i++) begin
         if (r_out !== 4'b0000) moves.push_back(r_out);
         if (done === 1'b1) dones.push_back(i);
         tick();
      end
      total++;
      if (moves.size() != 4 || dones.size() != 4) begin
         bad++;
         $display("FAIL fill_counts moves=%0d dones=%0d want 4 4", moves.size(), dones.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (moves[i] !== want_moves[i]) begin
               bad++;
               $display("FAIL fill_order idx=%0d r_out=%b want %b", i, moves[i], want_moves[i]);
            end
         end
         for (int i = 1; i < 4; i++) begin
            total++;
            if (dones[i] - dones[i-1] != 3) begin
               bad++;
               $display("FAIL fill_spacing idx=%0d got=%0d want 3", i, dones[i] - dones[i-1]);
            end
         end
      end
      total++;
      if (busy !== 1'b0 || level !== '0) begin
         bad++;
         $display("FAIL fill_drain busy=%b level=%0d want 0 0", busy, level);
      end
   endtask

   task automatic test_move_noop();
      int ndone;
      int nen;
      ndone = 0;
      nen   = 0;
      drive(1'b1, 1'b0, 2'd1, 2'd1);
      tick();
      drive(1'b0, 1'b0, 2'd0, 2'd0);
      for (int i = 0; i < 6; i++) begin
         if ({cv_out, cv_in, r_out, r_in} !== 10'd0) nen++;
         if (done === 1'b1) ndone++;
         tick();
      end
      total++;
      if (nen != 0 || ndone != 1) begin
         bad++;
         $display("FAIL noop_move enable_cycles=%0d dones=%0d want 0 1", nen, ndone);
      end
   endtask

   task automatic test_abort();
      int ndone;
      drive(1'b1, 1'b1, 2'd0, 2'd1); tick();
      drive(1'b1, 1'b1, 2'd1, 2'd2); tick();
      drive(1'b1, 1'b0, 2'd2, 2'd3); tick();
      drive(1'b1, 1'b0, 2'd3, 2'd2); tick();
      drive(1'b0, 1'b0, 2'd0, 2'd0); tick();
      tick();
      total++;
      if (cv_in !== 1'b1 || r_out !== 4'b0010 || level !== LW'(2)) begin
         bad++;
         $display("FAIL abort_setup cv_in=%b r_out=%b level=%0d want 1 0010 2", cv_in, r_out, level);
      end
      abort = 1'b1;
      drive(1'b1, 1'b0, 2'd0, 2'd3);
      #1;
      total++;
      if (cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL abort_ready got=%b want 0", cmd_ready);
      end
      tick();
      abort = 1'b0;
      drive(1'b0, 1'b0, 2'd0, 2'd0);
      total++;
      if ({done, cv_out, cv_in, r_out, r_in} !== 11'd0 || level !== '0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_flush out=%b level=%0d busy=%b want 0 0 0",
                  {done, cv_out, cv_in, r_out, r_in}, level, busy);
      end
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         if (done === 1'b1 || level !== '0 || r_out !== 4'b0000) ndone++;
         tick();
      end
      total++;
      if (ndone != 0) begin
         bad++;
         $display("FAIL abort_quiet active_cycles=%0d want 0", ndone);
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 1'b1, 2'd2, 2'd0);
      tick();
      drive(1'b0, 1'b0, 2'd0, 2'd0);
      tick();
      tick();
      total++;
      if (cv_out !== 1'b1 || r_in !== 4'b0001) begin
         bad++;
         $display("FAIL arst_setup cv_out=%b r_in=%b want 1 0001", cv_out, r_in);
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({done, cv_out, cv_in, r_out, r_in} !== 11'd0 || busy !== 1'b0 ||
          level !== '0 || cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL arst_immediate out=%b busy=%b level=%0d ready=%b want 0 0 0 1",
                  {done, cv_out, cv_in, r_out, r_in}, busy, level, cmd_ready);
      end
      tick();
      rst = 1'b0;
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL arst_after done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_random();
      logic [10:0] e;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (i < 450) begin
            drive(($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            abort = ($urandom_range(0, 39) == 0);
         end else begin
            drive(1'b0, 1'b0, 2'd0, 2'd0);
            abort = 1'b0;
         end
         #1;
         total++;
         if (cmd_ready !== ((mq.size() < DEPTH) && !abort)) begin
            bad++;
            $display("FAIL rnd_ready cyc=%0d got=%b want=%b", i, cmd_ready,
                     ((mq.size() < DEPTH) && !abort));
         end
         tick();
         e = exp_vec();
         total++;
         if ({done, cv_out, cv_in, r_out, r_in} !== e) begin
            bad++;
            $display("FAIL rnd_outputs cyc=%0d got=%b want=%b", i,
                     {done, cv_out, cv_in, r_out, r_in}, e);
         end
         total++;
         if (level !== LW'(mq.size()) ||
             busy !== ((sq.size() > 0) || (mq.size() > 0))) begin
            bad++;
            $display("FAIL rnd_status cyc=%0d level=%0d busy=%b want level=%0d busy=%b",
                     i, level, busy, mq.size(), ((sq.size() > 0) || (mq.size() > 0)));
         end
      end
      abort = 1'b0;
   endtask

   initial begin
      test_reset();
      test_move();
      test_convert_inplace();
      test_fill();
      test_move_noop();
      test_abort();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cc_xfer_sequencer.md
# cc_xfer_sequencer

Command-driven sequencer for the code converter's four-register shared-bus datapath and its conversion unit. It queues register-transfer commands and decodes each into a contention-free series of one-hot register/converter enables. It reports completion per command. It sits between the host control logic and the R1–R4 / converter load and drive enables. Only one source drives the bus in any cycle.

## Interface
Parameters:
- DEPTH, 4, command FIFO depth; power of two, ≥2.
- LW, $clog2(DEPTH)+1, width of `level`.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- abort  in  1  synchronous flush of queue and in-flight command.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !full && !abort.
- cmd_op  in  1  0 = MOVE, 1 = CONVERT.
- cmd_src  in  2  source register index (0→R1 … 3→R4).
- cmd_dst  in  2  destination register index.
- r_in  out  4  one-hot load enables, bit i = R(i+1)_in.
- r_out  out  4  one-hot bus-drive enables, bit i = R(i+1)_out.
- cv_in  out  1  converter loads from bus.
- cv_out  out  1  converter drives bus.
- busy  out  1  state ≠ IDLE or FIFO non-empty.
- done  out  1  one-cycle pulse per completed command.
- level  out  LW  FIFO occupancy, 0..DEPTH.

## Operation
- Push: cmd_valid && cmd_ready at the clock edge writes {op, src, dst} at the tail.
- The FIFO has no bypass. A command is poppable from the cycle after its push.
- FSM states are IDLE, MOVE, CV_LOAD, CV_STORE and DONE. Current-command fields are held in the `cur` registers.
  - IDLE: if FIFO non-empty, pop the head into `cur`. Go to MOVE (op=0) or CV_LOAD (op=1). Otherwise stay in IDLE.
  - MOVE: r_out[src]=1 and r_in[dst]=1. If src==dst, all enables stay 0 (no-op). Go to DONE.
  - CV_LOAD: r_out[src]=1 and cv_in=1. Go to CV_STORE.
  - CV_STORE: cv_out=1 and r_in[dst]=1. src==dst is legal (in-place conversion). Go to DONE.
  - DONE: done=1. Go to IDLE.
- Outputs are Moore outputs, decoded only from state and `cur`. Enables are all 0 in IDLE and DONE.
- Invariants:
  - popcount(r_out)+cv_out ≤ 1.
  - popcount(r_in)+cv_in ≤ 1.
  - r_out[i] && r_in[i] never both 1.
- Simultaneous push and pop leave `level` unchanged. Pointers wrap modulo DEPTH.
- When full, cmd_ready=0 and offered commands are not written, whatever cmd_valid is.
- abort at an edge:
  - FIFO is emptied (level=0) and the state goes to IDLE.
  - The in-flight command is dropped with no done pulse.
  - A same-cycle push is discarded.
- abort takes priority over every push, pop and transition.
- rst asserted asynchronously forces the reset state below, including mid-command. No done pulse is generated.

## Timing
- Reset values:
  - State IDLE, FIFO empty, level=0, `cur`=0.
  - r_in=0, r_out=0, cv_in=0, cv_out=0, busy=0, done=0.
  - cmd_ready=1 (unless abort is high).
- The push at edge k is popped at edge k+1, assuming an empty FIFO and IDLE.
- MOVE sequence:
  - enables valid in cycle k+1→k+2;
  - done high in cycle k+2→k+3;
  - IDLE at k+3.
- CONVERT sequence:
  - CV_LOAD in k+1→k+2;
  - CV_STORE in k+2→k+3;
  - done in k+3→k+4.
- Back-to-back throughput (queue pre-loaded):
  - MOVE: 3 cycles per command, since IDLE must pop.
  - CONVERT: 4 cycles per command.
- busy rises the cycle after the first push. It falls in the cycle after the final DONE, provided the queue is empty.

## Test plan
- Reset, then push MOVE src=0 dst=2 at edge k:
  - r_out=0001 and r_in=0100 in cycle k+1 only;
  - done=1 in cycle k+2 only;
  - busy low from k+3.
- Push CONVERT src=3 dst=3:
  - cycle 1: r_out=1000, cv_in=1, r_in=0000;
  - cycle 2: cv_out=1, r_in=1000, r_out=0000;
  - one done pulse.
- Fill DEPTH=4 MOVEs while the FSM is busy:
  - level reaches 4 and cmd_ready=0;
  - a 5th cmd_valid is ignored;
  - exactly 4 done pulses occur, in FIFO order, at 3-cycle spacing.
- MOVE src=1 dst=1: all enables stay 0 throughout and done still pulses once.
- Assert abort during CV_LOAD with 2 commands queued:
  - next cycle all enables=0, level=0, state IDLE;
  - no done pulses;
  - a push in the abort cycle is not stored.
- Assert rst asynchronously during CV_STORE:
  - outputs go to reset values immediately, without waiting for a clock edge;
  - the bus-exclusivity invariants are checked by assertion on every cycle of all tests.
